pe_bram_responder: RTL

Responder side of the PE controller's BRAM port: a single-clock word-addressed memory that serves the controller's reads and result write-backs, plus a host-side access port and a start/done mailbox. It sits between the host (AXI-lite bridge or testbench) and the PE controller. It holds the packed matrix, the vector and the result region, and sequences one compute run per host command.

---
 rtl/pe_bram_responder_pkg.sv | 7 +
 rtl/pe_bram_responder_if.sv | 20 ++
 rtl/pe_bram_responder_bram_sp_be.sv | 17 +
 rtl/pe_bram_responder.sv | 73 +++++++
 4 files changed

// File: rtl/pe_bram_responder_pkg.sv
// pe_bram_responder_pkg: run-state encoding and memory region map (word indices)
package pe_bram_responder_pkg;
   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_BUSY, S_DONE, S_ERR} state_t;
   localparam int MAT_BASE = 0;
   localparam int VEC_BASE = 2048;
   localparam int RES_BASE = 4160;
endpackage

// File: rtl/pe_bram_responder_if.sv
// pe_bram_responder_if: controller BRAM port, host access port and start/done mailbox
interface pe_bram_responder_if #(parameter int ADDR_W = 13);
   logic [31:0] bram_addr, bram_wrdata, bram_rddata;
   logic [3:0] bram_we;
   logic [ADDR_W-1:0] host_addr;
   logic [31:0] host_wrdata, host_rddata;
   logic host_we, host_re, host_rvalid, host_start, host_ack;
   logic pe_start, pe_done, busy, run_done, run_err;
   logic [15:0] wr_count;
   modport slave (
      input bram_addr, bram_wrdata, bram_we, host_addr, host_wrdata, host_we, host_re,
            host_start, host_ack, pe_done,
      output bram_rddata, host_rddata, host_rvalid, pe_start, busy, run_done, run_err, wr_count
   );
   modport master (
      output bram_addr, bram_wrdata, bram_we, host_addr, host_wrdata, host_we, host_re,
             host_start, host_ack, pe_done,
      input bram_rddata, host_rddata, host_rvalid, pe_start, busy, run_done, run_err, wr_count
   );
endinterface

// File: rtl/pe_bram_responder_bram_sp_be.sv
// bram_sp_be: single-port read-first 32-bit memory with per-byte write enables
module bram_sp_be #(
   parameter int AW = 13
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wrdata,
   output logic [31:0]   rddata
);
   logic [31:0] mem [2**AW];
   always_ff @(posedge clk) begin
      rddata <= mem[addr];
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wrdata[8*i +: 8];
   end
endmodule

// File: rtl/pe_bram_responder.sv
// pe_bram_responder: BRAM responder muxing one memory port between host and PE controller per run state
module pe_bram_responder
   import pe_bram_responder_pkg::*;
#(
   parameter int          ADDR_W  = 13,
   parameter int unsigned TIMEOUT = 65535
) (
   input logic aclk,
   input logic areset,
   pe_bram_responder_if.slave bus
);
   state_t state, next;
   logic [31:0] tcnt;
   logic [15:0] wr_count;
   logic [ADDR_W-1:0] bram_word, mem_addr;
   logic [3:0] mem_we;
   logic [31:0] mem_wrdata, mem_rddata;
   logic oor, ctl, host_act, host_sel, bram_sel, rvalid, run_done, run_err;
   assign bram_word = bus.bram_addr[ADDR_W+1:2];
   assign oor = |bus.bram_addr[31:ADDR_W+2];
   assign ctl = state == S_BUSY;
   assign host_act = bus.host_re | bus.host_we;
   // outside BUSY the controller still gets reads whenever the host leaves the port free
   assign mem_addr = (ctl || !host_act) ? bram_word : bus.host_addr;
   assign mem_we = ctl ? (oor ? 4'h0 : bus.bram_we) : {4{bus.host_we}};
   assign mem_wrdata = ctl ? bus.bram_wrdata : bus.host_wrdata;

   bram_sp_be #(.AW(ADDR_W)) u_mem (
      .clk(aclk), .addr(mem_addr), .we(mem_we), .wrdata(mem_wrdata), .rddata(mem_rddata)
   );

   always_comb begin
      next = state;
      case (state)
         S_IDLE:   next = bus.host_start ? S_LAUNCH : S_IDLE;
         S_LAUNCH: next = S_BUSY;
         S_BUSY:   next = bus.pe_done ? S_DONE : (tcnt == TIMEOUT - 1) ? S_ERR : S_BUSY;
         default:  next = bus.host_ack ? S_IDLE : state;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state    <= S_IDLE;
         tcnt     <= '0;
         wr_count <= '0;
         run_done <= 1'b0;
         run_err  <= 1'b0;
         rvalid   <= 1'b0;
         host_sel <= 1'b0;
         bram_sel <= 1'b0;
      end else begin
         state    <= next;
         tcnt     <= ctl ? tcnt + 32'd1 : '0;
         wr_count <= (state == S_LAUNCH) ? '0 :
                     (ctl && |bus.bram_we && wr_count != 16'hFFFF) ? wr_count + 16'd1 : wr_count;
         run_done <= (run_done && !bus.host_ack) || (ctl && next == S_DONE);
         run_err  <= (run_err && !bus.host_ack) || (ctl && next == S_ERR) || oor || (ctl && bus.host_we);
         rvalid   <= bus.host_re;
         host_sel <= bus.host_re && !ctl;
         bram_sel <= !oor && (ctl || !host_act);
      end
   end

   assign bus.pe_start    = state == S_LAUNCH;
   assign bus.busy        = state == S_LAUNCH || state == S_BUSY;
   assign bus.run_done    = run_done;
   assign bus.run_err     = run_err;
   assign bus.wr_count    = wr_count;
   assign bus.host_rvalid = rvalid;
   assign bus.host_rddata = host_sel ? mem_rddata : '0;
   assign bus.bram_rddata = bram_sel ? mem_rddata : '0;
endmodule
